// File: rtl/core_bus_responder_if.sv
// Byte-bus and posted-write drain signals between the core, the responder and the external consumer.
interface core_bus_responder_if #(
    parameter int FIFO_AW = 3
);
    logic [19:0]      address;
    logic [7:0]       wdata;
    logic             wren;
    logic [7:0]       rdata;
    logic             ext_valid;
    logic [19:0]      ext_addr;
    logic [7:0]       ext_data;
    logic             ext_ready;
    logic             overflow;
    logic [FIFO_AW:0] fifo_level;

    modport master (
        output address, wdata, wren, ext_ready,
        input  rdata, ext_valid, ext_addr, ext_data, overflow, fifo_level
    );

    modport slave (
        input  address, wdata, wren, ext_ready,
        output rdata, ext_valid, ext_addr, ext_data, overflow, fifo_level
    );
endinterface

// File: rtl/core_bus_responder.sv
// Byte-RAM responder for the core bus; writes in the external window are mirrored into a posted-write FIFO.
// Define CORE_BUS_ROM_PROTECT_EN to make the ROM_BASE..ROM_BASE+ROM_SIZE region read-only in RAM.
module core_bus_responder #(
    parameter int          RAM_AW   = 16,
    parameter logic [19:0] EXT_BASE = 20'h0F000,
    parameter logic [19:0] EXT_SIZE = 20'h00800,
    parameter int          FIFO_AW  = 3,
    parameter logic [19:0] ROM_BASE = 20'h08000,
    parameter logic [19:0] ROM_SIZE = 20'h01000
) (
    input logic                 clock,
    input logic                 reset,
    core_bus_responder_if.slave bus
);
    localparam int          DEPTH  = 2 ** FIFO_AW;
    localparam logic [20:0] EXT_LO = {1'b0, EXT_BASE};
    localparam logic [20:0] EXT_HI = {1'b0, EXT_BASE} + {1'b0, EXT_SIZE};
    localparam logic [20:0] ROM_LO = {1'b0, ROM_BASE};
    localparam logic [20:0] ROM_HI = {1'b0, ROM_BASE} + {1'b0, ROM_SIZE};

    // Windows that run past the 20-bit address space would never match their top bytes.
    if (EXT_HI > 21'h100000) begin : g_ext_range_chk
        $error("external window exceeds the 20-bit address space");
    end
    if (ROM_HI > 21'h100000) begin : g_rom_range_chk
        $error("boot region exceeds the 20-bit address space");
    end

    logic [7:0]  mem [2 ** RAM_AW];
    logic [19:0] fa_q [DEPTH];
    logic [7:0]  fd_q [DEPTH];

    logic [7:0]         rdata_q;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               ovf_q, ovf_d;

    logic [20:0]       addr21;
    logic              in_ram, in_ext, ram_we;
    logic              valid, full, pop, push, push_acc;
    logic [RAM_AW-1:0] ram_idx;

    assign addr21  = {1'b0, bus.address};
    assign in_ram  = (bus.address >> RAM_AW) == '0;
    assign in_ext  = (addr21 >= EXT_LO) && (addr21 < EXT_HI);
    assign ram_idx = bus.address[RAM_AW-1:0];

`ifdef CORE_BUS_ROM_PROTECT_EN
    logic in_rom;
    assign in_rom = (addr21 >= ROM_LO) && (addr21 < ROM_HI);
    assign ram_we = bus.wren && in_ram && !in_rom && !reset;
`else
    assign ram_we = bus.wren && in_ram && !reset;
`endif

    // Read-first RAM: the registered read sees the byte before a same-edge write.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            mem[ram_idx] <= bus.wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= in_ram ? mem[ram_idx] : 8'hFF;
        end
    end

    assign valid    = level_q != '0;
    assign full     = level_q[FIFO_AW];
    assign pop      = valid && bus.ext_ready;
    assign push     = bus.wren && in_ext && !reset;
    // When full, a same-cycle pop frees the head slot, which is exactly wr_ptr.
    assign push_acc = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_acc, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (push && !push_acc) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_acc) begin
            fa_q[wr_ptr_q] <= bus.address;
            fd_q[wr_ptr_q] <= bus.wdata;
        end
    end

    assign bus.rdata      = rdata_q;
    assign bus.ext_valid  = valid;
    assign bus.ext_addr   = valid ? fa_q[rd_ptr_q] : '0;
    assign bus.ext_data   = valid ? fd_q[rd_ptr_q] : '0;
    assign bus.overflow   = ovf_q;
    assign bus.fifo_level = level_q;
endmodule
